// File: rtl/reg_wb_pkg.sv
// Shared widths, the hardwired-zero register number and the queued write-back
// entry layout for the register-file writer front end.
package reg_wb_pkg;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [DEFAULT_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_entry;
endpackage

// File: rtl/reg_writeback_queue_if.sv
// Valid/ready result channel feeding the write-back queue.
interface reg_writeback_queue_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;

  modport master (output res_valid, output res_addr, output res_data, input res_ready);
  modport slave  (input res_valid, input res_addr, input res_data, output res_ready);
endinterface

// File: rtl/reg_wb_fifo.sv
// In-order entry storage with per-slot valid bits; every slot is exposed so the
// top level can search queued writes for forwarding and the pending scoreboard.
module reg_wb_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [ADDR_W-1:0]              pushAddr,
  input  logic [DATA_W-1:0]              pushData,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entAddr,
  output logic [DEPTH-1:0][DATA_W-1:0]   entData,
  output logic [DEPTH-1:0]               entValid,
  output logic [$clog2(DEPTH)-1:0]       rdPtr,
  output logic [$clog2(DEPTH):0]         count
);
  logic [$clog2(DEPTH)-1:0] wrPtr;

  // Callers never push when full nor pop when empty, so push and pop never target the same slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      entValid <= '0;
      entAddr  <= '0;
      entData  <= '0;
    end else if (flush) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      entValid <= '0;
    end else begin
      if (push) begin
        entAddr[wrPtr]  <= pushAddr;
        entData[wrPtr]  <= pushData;
        entValid[wrPtr] <= 1'b1;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (pop) begin
        entValid[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Register-file writer front end: buffers completed results, retires one per
// cycle, and answers decode's pending/forwarding queries from the queue contents.
module reg_writeback_queue
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_writeback_queue_if.slave   res,
  input  logic                   wr_stall,
  input  logic                   flush,
  output logic                   write,
  output logic [ADDR_W-1:0]      dAddr,
  output logic [DATA_W-1:0]      data,
  input  logic [ADDR_W-1:0]      chk_addr,
  output logic                   chk_hit,
  output logic [DATA_W-1:0]      chk_data,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic                         push;
  logic [DEPTH-1:0][ADDR_W-1:0] entAddr;
  logic [DEPTH-1:0][DATA_W-1:0] entData;
  logic [DEPTH-1:0]             entValid;
  logic [PTR_W-1:0]             rdPtr;
  logic [PTR_W-1:0]             idx;

  assign res.res_ready = (count < FULL_CNT) && !flush;
  // Writes to $0 complete the handshake but are never stored.
  assign push  = res.res_valid && res.res_ready && (res.res_addr != ZERO_ADDR);
  assign write = (count != '0) && !wr_stall && !flush;
  assign dAddr = write ? entAddr[rdPtr] : '0;
  assign data  = write ? entData[rdPtr] : '0;

  reg_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (write),
    .flush    (flush),
    .pushAddr (res.res_addr),
    .pushData (res.res_data),
    .entAddr  (entAddr),
    .entData  (entData),
    .entValid (entValid),
    .rdPtr    (rdPtr),
    .count    (count)
  );

  // Walk oldest to youngest from the head so the last match seen is the youngest.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PTR_W'(k);
      if (entValid[idx] && (entAddr[idx] == chk_addr) && (chk_addr != ZERO_ADDR)) begin
        chk_hit  = 1'b1;
        chk_data = entData[idx];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entValid[i])
        pending[entAddr[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus a negedge scoreboard
// monitor that models the queue and checks every retired write and lookup.
module tb_reg_writeback_queue;
  import reg_wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_stall;
  logic          flush;
  logic          write;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] data;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;
  logic [DW-1:0] chk_data;
  logic [2**AW-1:0] pending;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;
  wb_entry sbq[$];

  always #5 clk = ~clk;

  reg_writeback_queue_if #(.ADDR_W(AW), .DATA_W(DW)) resIf ();

  reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .res      (resIf),
    .wr_stall (wr_stall),
    .flush    (flush),
    .write    (write),
    .dAddr    (dAddr),
    .data     (data),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .chk_data (chk_data),
    .pending  (pending),
    .count    (count)
  );

  // Reference model: compares against the queue state before the coming edge, then updates it.
  always @(negedge clk) begin : monitor
    wb_entry          head;
    logic             expWrite;
    logic             expReady;
    logic             expHit;
    logic [DW-1:0]    expChk;
    logic [2**AW-1:0] expPend;
    int               n;
    if (!reset) begin
      sbq.delete();
    end else begin
      n        = sbq.size();
      expWrite = (n != 0) && !wr_stall && !flush;
      expReady = (n < DEPTH) && !flush;
      expHit   = 1'b0;
      expChk   = '0;
      expPend  = '0;
      foreach (sbq[i]) begin
        expPend[sbq[i].addr] = 1'b1;
        if (chk_addr != 0 && sbq[i].addr == chk_addr) begin
          expHit = 1'b1;
          expChk = sbq[i].data;
        end
      end
      checks++;
      if (count !== 3'(n)) begin
        errors++; $display("FAIL mon_count: got %0d expected %0d at %0t", count, n, $time);
      end
      checks++;
      if (write !== expWrite) begin
        errors++; $display("FAIL mon_write: got %b expected %b at %0t", write, expWrite, $time);
      end
      checks++;
      if (resIf.res_ready !== expReady) begin
        errors++; $display("FAIL mon_ready: got %b expected %b at %0t", resIf.res_ready, expReady, $time);
      end
      checks++;
      if (chk_hit !== expHit || chk_data !== expChk) begin
        errors++; $display("FAIL mon_fwd: got hit=%b data=%h expected hit=%b data=%h at %0t",
                           chk_hit, chk_data, expHit, expChk, $time);
      end
      checks++;
      if (pending !== expPend) begin
        errors++; $display("FAIL mon_pending: got %h expected %h at %0t", pending, expPend, $time);
      end
      checks++;
      if (expWrite) begin
        head = sbq.pop_front();
        if (dAddr !== head.addr || data !== head.data) begin
          errors++; $display("FAIL mon_retire: got %0d/%h expected %0d/%h at %0t",
                             dAddr, data, head.addr, head.data, $time);
        end
      end else if (dAddr !== '0 || data !== '0) begin
        errors++; $display("FAIL mon_idle_bus: got %0d/%h expected 0/0 at %0t", dAddr, data, $time);
      end
      if (flush)
        sbq.delete();
      else if (resIf.res_valid && expReady && resIf.res_addr != 0)
        sbq.push_back(wb_entry'{addr: resIf.res_addr, data: resIf.res_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    resIf.res_valid = 1'b1;
    resIf.res_addr  = a;
    resIf.res_data  = d;
    tick();
    resIf.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    resIf.res_valid = 1'b0;
    resIf.res_addr  = '0;
    resIf.res_data  = '0;
    wr_stall = 1'b0;
    flush    = 1'b0;
    chk_addr = '0;
    reset    = 1'b0;
    #12;
    checks++;
    if (write !== 1'b0 || count !== 3'd0 || pending !== '0 || chk_hit !== 1'b0 || dAddr !== '0 || data !== '0) begin
      errors++; $display("FAIL reset_outputs: write=%b count=%0d pending=%h hit=%b dAddr=%0d data=%h required all 0",
                         write, count, pending, chk_hit, dAddr, data);
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (resIf.res_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", resIf.res_ready);
    end
  endtask

  task automatic test_single();
    push(5'd1, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (write !== 1'b1 || dAddr !== 5'd1 || data !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL single_write: got %b/%0d/%h required 1/1/ffffffff", write, dAddr, data);
    end
    tick();
    #1;
    checks++;
    if (count !== 3'd0 || write !== 1'b0) begin
      errors++; $display("FAIL single_drained: count=%0d write=%b required 0/0", count, write);
    end
  endtask

  task automatic test_stall_full();
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(3 + i), 32'h100 + i);
    #1;
    checks++;
    if (count !== 3'd4 || resIf.res_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: count=%0d ready=%b required 4/0", count, resIf.res_ready);
    end
    resIf.res_valid = 1'b1;
    resIf.res_addr  = 5'd9;
    resIf.res_data  = 32'hBAD0_0009;
    tick();
    resIf.res_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL full_reject: count=%0d required 4", count);
    end
    wr_stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin tick(); #1; end
      checks++;
      if (write !== 1'b1 || dAddr !== 5'(3 + i)) begin
        errors++; $display("FAIL drain_order: write=%b dAddr=%0d required 1/%0d", write, dAddr, 3 + i);
      end
    end
    tick();
    #1;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL drain_empty: count=%0d required 0", count);
    end
  endtask

  task automatic test_forward();
    wr_stall = 1'b1;
    push(5'd7, 32'hAAAA_0000);
    push(5'd7, 32'h5555_FFFF);
    chk_addr = 5'd7;
    #1;
    checks++;
    if (chk_hit !== 1'b1 || chk_data !== 32'h5555_FFFF || pending[7] !== 1'b1) begin
      errors++; $display("FAIL fwd_youngest: hit=%b data=%h pend7=%b required 1/5555ffff/1", chk_hit, chk_data, pending[7]);
    end
    chk_addr = 5'd3;
    #1;
    checks++;
    if (chk_hit !== 1'b0 || chk_data !== '0) begin
      errors++; $display("FAIL fwd_miss: hit=%b data=%h required 0/0", chk_hit, chk_data);
    end
    chk_addr = 5'd7;
    wr_stall = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (pending[7] !== 1'b0 || chk_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_drained: pend7=%b hit=%b required 0/0", pending[7], chk_hit);
    end
    chk_addr = 5'd8;
    resIf.res_valid = 1'b1;
    resIf.res_addr  = 5'd8;
    resIf.res_data  = 32'h0000_DEAD;
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_incoming_hidden: hit=%b required 0", chk_hit);
    end
    tick();
    resIf.res_valid = 1'b0;
    #1;
    checks++;
    if (chk_hit !== 1'b1 || chk_data !== 32'h0000_DEAD) begin
      errors++; $display("FAIL fwd_after_accept: hit=%b data=%h required 1/0000dead", chk_hit, chk_data);
    end
    tick();
  endtask

  task automatic test_addr_zero();
    chk_addr = 5'd0;
    resIf.res_valid = 1'b1;
    resIf.res_addr  = 5'd0;
    resIf.res_data  = 32'h1234_5678;
    #1;
    checks++;
    if (resIf.res_ready !== 1'b1) begin
      errors++; $display("FAIL zero_ready: got %b required 1", resIf.res_ready);
    end
    tick();
    resIf.res_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || write !== 1'b0 || chk_hit !== 1'b0) begin
      errors++; $display("FAIL zero_dropped: count=%0d write=%b hit=%b required 0/0/0", count, write, chk_hit);
    end
    tick();
    #1;
    checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL zero_no_write: write=%b required 0", write);
    end
  endtask

  task automatic test_flush();
    wr_stall = 1'b1;
    push(5'd10, 32'h0000_0010);
    push(5'd11, 32'h0000_0011);
    #1;
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("FAIL flush_setup: count=%0d required 2", count);
    end
    wr_stall = 1'b0;
    flush    = 1'b1;
    resIf.res_valid = 1'b1;
    resIf.res_addr  = 5'd12;
    resIf.res_data  = 32'h00C0_FFEE;
    #1;
    checks++;
    if (resIf.res_ready !== 1'b0 || write !== 1'b0) begin
      errors++; $display("FAIL flush_gates: ready=%b write=%b required 0/0", resIf.res_ready, write);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || resIf.res_ready !== 1'b1) begin
      errors++; $display("FAIL flush_cleared: count=%0d ready=%b required 0/1", count, resIf.res_ready);
    end
    tick();
    resIf.res_valid = 1'b0;
    #1;
    checks++;
    if (write !== 1'b1 || dAddr !== 5'd12 || data !== 32'h00C0_FFEE) begin
      errors++; $display("FAIL flush_next_push: got %b/%0d/%h required 1/12/00c0ffee", write, dAddr, data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    resIf.res_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      resIf.res_addr = 5'(1 + i);
      resIf.res_data = $urandom;
      tick();
    end
    resIf.res_valid = 1'b0;
    tick();
    #1;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL b2b_empty: count=%0d required 0", count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      resIf.res_valid = ($urandom_range(0, 3) != 0);
      resIf.res_addr  = 5'($urandom_range(0, 7));
      resIf.res_data  = $urandom;
      wr_stall        = ($urandom_range(0, 2) == 0);
      flush           = ($urandom_range(0, 15) == 0);
      chk_addr        = 5'($urandom_range(0, 7));
      tick();
    end
    resIf.res_valid = 1'b0;
    wr_stall = 1'b0;
    flush    = 1'b0;
    repeat (DEPTH + 1) tick();
    #1;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL random_drain: count=%0d required 0", count);
    end
  endtask

  task automatic test_async_reset();
    wr_stall = 1'b1;
    push(5'd20, 32'h0000_0020);
    push(5'd21, 32'h0000_0021);
    push(5'd22, 32'h0000_0022);
    #1;
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL areset_setup: count=%0d required 3", count);
    end
    wr_stall = 1'b0;
    reset    = 1'b0;
    #1;
    checks++;
    if (write !== 1'b0 || count !== 3'd0 || pending !== '0) begin
      errors++; $display("FAIL areset_immediate: write=%b count=%0d pending=%h required 0/0/0", write, count, pending);
    end
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++;
      if (write !== 1'b0 || count !== 3'd0) begin
        errors++; $display("FAIL areset_no_stale: write=%b count=%0d required 0/0", write, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_full();
    test_forward();
    test_addr_zero();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d entries required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
